// File: rtl/aes_pkg.sv
// Shared AES controller definitions: block/round widths, FSM states and
// the working state/key pair carried between rounds.
package aes_pkg;
    localparam int AES_BLOCK_W       = 128;
    localparam int AES_ROUND_W       = 5;
    localparam int AES128_NUM_ROUNDS = 10;
    localparam int AES_WAIT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } aes_state_e;

    typedef logic [0:AES_BLOCK_W-1] aes_block_t;
    typedef logic [0:AES_ROUND_W-1] aes_round_t;

    typedef struct packed {
        aes_block_t blk;
        aes_block_t key;
    } aes_work_t;
endpackage

// File: rtl/aes_round_timer.sv
// Per-round wait counter and round index; strobes the datapath capture
// edge and flags when the current round is the last one.
module aes_round_timer
    import aes_pkg::*;
#(
    parameter int DP_LATENCY = 2,
    parameter int NUM_ROUNDS = AES128_NUM_ROUNDS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output aes_round_t round_cnt,
    output logic       capture,
    output logic       last_round
);
    logic [AES_WAIT_W-1:0] wait_cnt;

    assign capture    = en && (wait_cnt == AES_WAIT_W'(DP_LATENCY - 1));
    assign last_round = (round_cnt == AES_ROUND_W'(NUM_ROUNDS));

    // Round index saturates at the last round; the FSM leaves RUN there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            round_cnt <= '0;
        end else if (clr) begin
            wait_cnt  <= '0;
            round_cnt <= '0;
        end else if (en) begin
            if (capture) begin
                wait_cnt <= '0;
                if (!last_round)
                    round_cnt <= round_cnt + AES_ROUND_W'(1);
            end else begin
                wait_cnt <= wait_cnt + AES_WAIT_W'(1);
            end
        end
    end
endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: feeds an external round datapath one round at a
// time, waits out its latency, and returns the final block with a done pulse.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int DP_LATENCY = 2,
    parameter int NUM_ROUNDS = AES128_NUM_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [0:AES_BLOCK_W-1] plaintext,
    input  logic [0:AES_BLOCK_W-1] key,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [0:AES_BLOCK_W-1] ciphertext,
    output logic [0:AES_BLOCK_W-1] dp_in,
    output logic [0:AES_BLOCK_W-1] dp_key,
    output logic [0:AES_ROUND_W-1] dp_round,
    input  logic [0:AES_BLOCK_W-1] dp_out,
    input  logic [0:AES_BLOCK_W-1] dp_key_out
);
    aes_state_e state_q, state_d;
    aes_work_t  work_q;
    aes_round_t round_cnt;
    logic       load, run_en, capture, last_round;

    assign load   = (state_q == ST_IDLE) && start;
    assign run_en = (state_q == ST_RUN) && !abort;

    aes_round_timer #(
        .DP_LATENCY (DP_LATENCY),
        .NUM_ROUNDS (NUM_ROUNDS)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (load),
        .en         (run_en),
        .round_cnt  (round_cnt),
        .capture    (capture),
        .last_round (last_round)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)                      state_d = ST_IDLE;
                else if (capture && last_round) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == ST_IDLE);
        busy  = (state_q == ST_RUN);
        done  = (state_q == ST_DONE);
    end

    // Ciphertext takes the block state_reg receives on the final capture,
    // so it is already valid during the DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q     <= '0;
            ciphertext <= '0;
        end else if (load) begin
            work_q <= '{blk: plaintext, key: key};
        end else if (capture) begin
            work_q <= '{blk: dp_out, key: dp_key_out};
            if (last_round)
                ciphertext <= dp_out;
        end
    end

    assign dp_in    = work_q.blk;
    assign dp_key   = work_q.key;
    assign dp_round = round_cnt;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: one instance with a behavioural AES-128 round
// model at default latency, one with an increment stub at DP_LATENCY=3.
`timescale 1ns/1ps
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_rst_n, a_start, a_abort, a_ready, a_busy, a_done;
    logic [0:127] a_pt, a_key, a_ct, a_dp_in, a_dp_key, a_dp_out, a_dp_key_out;
    logic [0:4]   a_dp_round;

    logic         s_rst_n, s_start, s_abort, s_ready, s_busy, s_done;
    logic [0:127] s_pt, s_key, s_ct, s_dp_in, s_dp_key, s_dp_out, s_dp_key_out;
    logic [0:4]   s_dp_round;

    aes_round_ctrl u_aes (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .abort(a_abort),
        .plaintext(a_pt), .key(a_key), .ready(a_ready), .busy(a_busy),
        .done(a_done), .ciphertext(a_ct), .dp_in(a_dp_in), .dp_key(a_dp_key),
        .dp_round(a_dp_round), .dp_out(a_dp_out), .dp_key_out(a_dp_key_out)
    );

    aes_round_ctrl #(.DP_LATENCY(3)) u_stub (
        .clk(clk), .rst_n(s_rst_n), .start(s_start), .abort(s_abort),
        .plaintext(s_pt), .key(s_key), .ready(s_ready), .busy(s_busy),
        .done(s_done), .ciphertext(s_ct), .dp_in(s_dp_in), .dp_key(s_dp_key),
        .dp_round(s_dp_round), .dp_out(s_dp_out), .dp_key_out(s_dp_key_out)
    );

    // ---------------- AES-128 round reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    // Multiplicative inverse as x^254, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] s = x;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [0:127] aes_round(input logic [0:127] in,
                                               input logic [0:127] k, input int rnd);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] o;
        if (rnd == 0) return in ^ k;
        for (int i = 0; i < 16; i++) s[i] = sbox(in[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c + r] = s[4*((c + r) % 4) + r];
        if (rnd != 10) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [0:127] key_next(input logic [0:127] k, input int rnd);
        logic [7:0]  rc = 8'h01;
        logic [31:0] w0, w1, w2, w3, tmp;
        for (int i = 0; i < rnd; i++) rc = xt(rc);
        w0 = k[0 +: 32]; w1 = k[32 +: 32]; w2 = k[64 +: 32]; w3 = k[96 +: 32];
        tmp = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        a_dp_out     = aes_round(a_dp_in, a_dp_key, int'(a_dp_round));
        a_dp_key_out = key_next(a_dp_key, int'(a_dp_round));
    end

    assign s_dp_out     = s_dp_in + 128'd1;
    assign s_dp_key_out = s_dp_key;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    // One encryption on the AES instance. Cycle k is the value sampled by the
    // k-th rising edge after the start-sampling edge; -1 disables an event.
    task automatic run_a(input logic [0:127] pt, input logic [0:127] key,
                         input bit with_abort, input int abort_at, input int rst_at,
                         input int st1, input int st2,
                         output int done_cyc, output int done_cnt, output logic [0:127] ct);
        done_cyc = -1; done_cnt = 0; ct = '0;
        @(negedge clk);
        a_start = 1'b1; a_abort = with_abort; a_pt = pt; a_key = key;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (a_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
                ct = a_ct;
            end
            if (k == 1) begin
                chk("run_busy", 128'(a_busy), 128'd1);
                chk("run_ready", 128'(a_ready), 128'd0);
                chk("run_dp_in_pt", a_dp_in, pt);
            end
            if (k == abort_at + 1) begin
                chk("abort_ready", 128'(a_ready), 128'd1);
                chk("abort_busy", 128'(a_busy), 128'd0);
            end
            if (k == rst_at + 1) begin
                chk("rst_ready", 128'(a_ready), 128'd1);
                chk("rst_busy", 128'(a_busy), 128'd0);
                chk("rst_ct", a_ct, 128'd0);
                chk("rst_dp_in", a_dp_in, 128'd0);
                chk("rst_dp_key", a_dp_key, 128'd0);
                chk("rst_dp_round", 128'(a_dp_round), 128'd0);
            end
            a_start = (k == st1) || (k == st2);
            a_abort = (k == abort_at);
            a_rst_n = !(k == rst_at);
            a_pt    = rnd128();
            a_key   = rnd128();
        end
        a_start = 1'b0; a_abort = 1'b0; a_rst_n = 1'b1;
    endtask

    task automatic run_s(input logic [0:127] pt, input logic [0:127] exp_ct);
        int done_cyc = -1;
        int done_cnt = 0;
        @(negedge clk);
        s_start = 1'b1; s_pt = pt; s_key = rnd128();
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (s_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
                chk("stub_ct", s_ct, exp_ct);
            end
            if (k <= 33) chk("stub_round", 128'(s_dp_round), 128'((k - 1) / 3));
            s_start = 1'b0;
            s_pt    = rnd128();
        end
        chk("stub_done_cycle", 128'(done_cyc), 128'd34);
        chk("stub_done_count", 128'(done_cnt), 128'd1);
    endtask

    typedef struct {
        string        name;
        logic [0:127] pt;
        logic [0:127] key;
        bit           with_abort;
        logic [0:127] ct;
    } avec_t;

    typedef struct {
        logic [0:127] pt;
        logic [0:127] ct;
    } svec_t;

    initial begin
        avec_t        avec [3];
        svec_t        svec [3];
        int           dc, dn;
        logic [0:127] ct;
        int           dcyc [$];

        avec[0] = '{"fips197_b", PT_B, KEY_B, 1'b0, CT_B};
        avec[1] = '{"fips197_c1", 128'h00112233445566778899aabbccddeeff,
                    128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        avec[2] = '{"all_zero", 128'h0, 128'h0, 1'b0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        svec[0] = '{128'h0, 128'h0000000000000000000000000000000b};
        svec[1] = '{128'hffffffffffffffffffffffffffffffff,
                    128'h0000000000000000000000000000000a};
        svec[2] = '{128'h0123456789abcdef00000000000000f8,
                    128'h0123456789abcdef0000000000000103};

        a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_pt = '0; a_key = '0;
        s_rst_n = 1'b0; s_start = 1'b0; s_abort = 1'b0; s_pt = '0; s_key = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 128'(a_ready), 128'd1);
        chk("reset_busy", 128'(a_busy), 128'd0);
        chk("reset_done", 128'(a_done), 128'd0);
        chk("reset_ct", a_ct, 128'd0);
        chk("reset_dp_in", a_dp_in, 128'd0);
        chk("reset_dp_key", a_dp_key, 128'd0);
        chk("reset_dp_round", 128'(a_dp_round), 128'd0);
        chk("reset_stub_ready", 128'(s_ready), 128'd1);
        a_rst_n = 1'b1; s_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // abort and start together in IDLE: start wins (fips197_c1 entry)
        foreach (avec[i]) begin
            run_a(avec[i].pt, avec[i].key, avec[i].with_abort, -1, -1, -1, -1, dc, dn, ct);
            chk({avec[i].name, "_done_cycle"}, 128'(dc), 128'd23);
            chk({avec[i].name, "_done_count"}, 128'(dn), 128'd1);
            chk({avec[i].name, "_ct"}, ct, avec[i].ct);
        end

        // start pulses while busy are ignored
        run_a(PT_B, KEY_B, 1'b0, -1, -1, 5, 12, dc, dn, ct);
        chk("ign_start_done_cycle", 128'(dc), 128'd23);
        chk("ign_start_done_count", 128'(dn), 128'd1);
        chk("ign_start_ct", ct, CT_B);

        // abort mid-run: back to IDLE, no done, ciphertext held
        run_a(128'h00112233445566778899aabbccddeeff, KEY_B, 1'b0, 10, -1, -1, -1, dc, dn, ct);
        chk("abort_done_count", 128'(dn), 128'd0);
        chk("abort_ct_hold", a_ct, CT_B);
        run_a(PT_B, KEY_B, 1'b0, -1, -1, -1, -1, dc, dn, ct);
        chk("post_abort_ct", ct, CT_B);
        chk("post_abort_done_cycle", 128'(dc), 128'd23);

        // one-cycle reset mid-run
        run_a(PT_B, KEY_B, 1'b0, -1, 15, -1, -1, dc, dn, ct);
        chk("rst_done_count", 128'(dn), 128'd0);
        run_a(PT_B, KEY_B, 1'b0, -1, -1, -1, -1, dc, dn, ct);
        chk("post_rst_ct", ct, CT_B);
        chk("post_rst_done_cycle", 128'(dc), 128'd23);

        // start held high: one block every 24 cycles
        @(negedge clk);
        a_start = 1'b1; a_pt = PT_B; a_key = KEY_B;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (a_done) begin
                dcyc.push_back(k);
                chk("cont_ct", a_ct, CT_B);
            end
        end
        a_start = 1'b0;
        chk("cont_done_count", 128'(dcyc.size()), 128'd3);
        if (dcyc.size() == 3) begin
            chk("cont_first", 128'(dcyc[0]), 128'd23);
            chk("cont_period1", 128'(dcyc[1] - dcyc[0]), 128'd24);
            chk("cont_period2", 128'(dcyc[2] - dcyc[1]), 128'd24);
        end
        repeat (30) @(negedge clk);

        // increment stub at DP_LATENCY=3
        foreach (svec[i]) run_s(svec[i].pt, svec[i].ct);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
